// File: rtl/jtframe_ba_arb_pkg.sv
// Shared types and helpers for the SDRAM bank-port arbiter.
// Used by jtframe_ba_arb and jtframe_rr_pick.
package jtframe_ba_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } ba_arb_st_t;

    // Width of a slot index; never less than one bit.
    function automatic int owner_w(input int slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward from ptr, wrapping.
// Returns a one-hot grant, its index and a valid flag.
module jtframe_rr_pick
    import jtframe_ba_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = owner_w(N)
)(
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         valid
);

    logic [W-1:0] scan;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        scan  = ptr;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[scan]) begin
                gnt[scan] = 1'b1;
                idx       = scan;
                valid     = 1'b1;
            end
            scan = (scan == W'(N - 1)) ? '0 : scan + 1'b1;
        end
    end

endmodule

// File: rtl/jtframe_ba_arb.sv
// Shares one SDRAM bank port among SLOTS requesters with round-robin grants held per burst.
// Define JTFRAME_BA_ARB_PRIO_EN to give slot 0 fixed top priority over a round-robin of the rest.
module jtframe_ba_arb
    import jtframe_ba_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = 23,
    parameter int DW    = 16
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SLOTS*AW-1:0]         slot_addr,
    input  logic [SLOTS-1:0]            slot_rd,
    input  logic [SLOTS-1:0]            slot_wr,
    input  logic [SLOTS*DW-1:0]         slot_din,
    input  logic [SLOTS*2-1:0]          slot_din_m,
    output logic [SLOTS-1:0]            slot_ack,
    output logic [SLOTS-1:0]            slot_dst,
    output logic [SLOTS-1:0]            slot_dok,
    output logic [SLOTS-1:0]            slot_rdy,
    output logic [AW-1:0]               ba_addr,
    output logic                        ba_rd,
    output logic                        ba_wr,
    output logic [DW-1:0]               ba_din,
    output logic [1:0]                  ba_din_m,
    input  logic                        ba_ack,
    input  logic                        ba_dst,
    input  logic                        ba_dok,
    input  logic                        ba_rdy,
    output ba_arb_st_t                  st,
    output logic [owner_w(SLOTS)-1:0]   ptr
);

    localparam int OW = owner_w(SLOTS);
    localparam logic [OW-1:0] LAST = OW'(SLOTS - 1);
`ifdef JTFRAME_BA_ARB_PRIO_EN
    localparam logic [OW-1:0] PTR_RST = OW'(1);
`else
    localparam logic [OW-1:0] PTR_RST = '0;
`endif

    // Handshake: a slot holds rd/wr high until it sees its one-cycle slot_ack;
    // the bank port sees ba_rd/ba_wr held until ba_ack, then dst/dok/rdy follow
    // and only the owner sees them, ending on ba_rdy.

    logic [SLOTS-1:0] req;
    logic [SLOTS-1:0] pick_req;
    logic [SLOTS-1:0] pk_gnt;
    logic [OW-1:0]    pk_idx;
    logic             pk_valid;

    logic [SLOTS-1:0] sel_gnt;
    logic [OW-1:0]    sel_idx;
    logic             sel_valid;

    logic [OW-1:0]    owner;
    logic [SLOTS-1:0] own_1h;
    logic [OW-1:0]    ptr_adv;

    ba_arb_st_t       st_nx;
    logic [OW-1:0]    ptr_nx;
    logic [OW-1:0]    owner_nx;
    logic [AW-1:0]    addr_nx;
    logic [DW-1:0]    din_nx;
    logic [1:0]       din_m_nx;
    logic             rd_nx;
    logic             wr_nx;
    logic             route;

    assign req = slot_rd | slot_wr;

`ifdef JTFRAME_BA_ARB_PRIO_EN
    // Slot 0 is served outside the rotation, so the picker never sees it.
    assign pick_req = req & ~SLOTS'(1);
`else
    assign pick_req = req;
`endif

    jtframe_rr_pick #(
        .N (SLOTS),
        .W (OW)
    ) u_pick (
        .req   (pick_req),
        .ptr   (ptr),
        .gnt   (pk_gnt),
        .idx   (pk_idx),
        .valid (pk_valid)
    );

    always_comb begin
        sel_gnt   = pk_gnt;
        sel_idx   = pk_idx;
        sel_valid = pk_valid;
`ifdef JTFRAME_BA_ARB_PRIO_EN
        if (req[0]) begin
            sel_gnt   = SLOTS'(1);
            sel_idx   = '0;
            sel_valid = 1'b1;
        end
`endif
    end

    always_comb begin
        ptr_adv = (owner == LAST) ? '0 : owner + 1'b1;
`ifdef JTFRAME_BA_ARB_PRIO_EN
        if (owner == '0) begin
            ptr_adv = ptr;
        end else if (ptr_adv == '0) begin
            ptr_adv = OW'(1);
        end
`endif
    end

    assign own_1h = SLOTS'(1) << owner;

    always_comb begin
        st_nx    = st;
        ptr_nx   = ptr;
        owner_nx = owner;
        addr_nx  = ba_addr;
        din_nx   = ba_din;
        din_m_nx = ba_din_m;
        rd_nx    = ba_rd;
        wr_nx    = ba_wr;
        case (st)
            IDLE: begin
                rd_nx = 1'b0;
                wr_nx = 1'b0;
                if (sel_valid) begin
                    owner_nx = sel_idx;
                    addr_nx  = slot_addr[sel_idx*AW +: AW];
                    din_nx   = slot_din[sel_idx*DW +: DW];
                    din_m_nx = slot_din_m[sel_idx*2 +: 2];
                    // Write wins when a slot raises both rd and wr.
                    wr_nx    = |(sel_gnt & slot_wr);
                    rd_nx    = |(sel_gnt & slot_rd) & ~(|(sel_gnt & slot_wr));
                    st_nx    = REQ;
                end
            end
            REQ: begin
                if (ba_ack) begin
                    rd_nx  = 1'b0;
                    wr_nx  = 1'b0;
                    ptr_nx = ptr_adv;
                    st_nx  = ba_rdy ? IDLE : BUSY;
                end else if (!req[owner]) begin
                    rd_nx = 1'b0;
                    wr_nx = 1'b0;
                    st_nx = IDLE;
                end
            end
            BUSY: begin
                if (ba_rdy) begin
                    st_nx = IDLE;
                end
            end
            default: begin
                rd_nx = 1'b0;
                wr_nx = 1'b0;
                st_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            ptr      <= PTR_RST;
            owner    <= '0;
            ba_addr  <= '0;
            ba_din   <= '0;
            ba_din_m <= 2'b11;
            ba_rd    <= 1'b0;
            ba_wr    <= 1'b0;
        end else begin
            st       <= st_nx;
            ptr      <= ptr_nx;
            owner    <= owner_nx;
            ba_addr  <= addr_nx;
            ba_din   <= din_nx;
            ba_din_m <= din_m_nx;
            ba_rd    <= rd_nx;
            ba_wr    <= wr_nx;
        end
    end

    // ack and rdy may land together in REQ, so the data strobes route there too.
    assign route    = (st == BUSY) || ((st == REQ) && ba_ack);
    assign slot_ack = ((st == REQ) && ba_ack) ? own_1h : '0;
    assign slot_dst = (route && ba_dst) ? own_1h : '0;
    assign slot_dok = (route && ba_dok) ? own_1h : '0;
    assign slot_rdy = (route && ba_rdy) ? own_1h : '0;

endmodule
